enemy_spawn_ctrl: RTL and testbench

- Schedules enemy tank respawns for the tank_bot instances during play.
- Owns the enemy budget: how many enemies remain to spawn and how many remain undestroyed.
- Picks a free enemy slot and a free spawn point after a countdown, then pulses that slot's revive input with the spawn coordinates.
- Sits between the FSM/bullet_collide outputs (die pulses, game start) and the tank_bot revive/position inputs; drives enemy_left to score_board.

---
 rtl/enemy_spawn_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_enemy_spawn_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/enemy_spawn_ctrl.sv
// Enemy respawn scheduler: owns the per-level enemy budget, picks a free slot and spawn point, pulses revive.
// Optional spawn shield: define ENEMY_SPAWN_SHIELD_EN.
module enemy_spawn_ctrl #(
  parameter int NUM_SLOTS     = 2,
  parameter int ENEMY_TOTAL   = 20,
  parameter int SPAWN_DELAY_S = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 tick_1s_i,
  input  logic                 game_start_i,
  input  logic                 game_active_i,
  input  logic [NUM_SLOTS-1:0] slot_die_i,
  input  logic [2:0]           spawn_blocked_i,
  output logic [NUM_SLOTS-1:0] slot_revive_o,
  output logic [9:0]           spawn_x_o,
  output logic [9:0]           spawn_y_o,
  output logic [NUM_SLOTS-1:0] slot_alive_o,
  output logic [5:0]           enemy_left_o,
  output logic                 level_clear_o,
  output logic [NUM_SLOTS-1:0] slot_shield_o,
  output logic [2:0]           dbg_state_o
);

  localparam int NUM_POINTS = 3;
  localparam logic [9:0] SPAWN_Y = 10'd32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SELECT = 3'd2,
    S_SPAWN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state;
  logic [NUM_SLOTS-1:0] r_alive;
  logic [NUM_SLOTS-1:0] r_slot_oh;
  logic [NUM_SLOTS-1:0] r_revive;
  logic [5:0]           r_to_spawn;
  logic [5:0]           r_left;
  logic [3:0]           r_cnt;
  logic [1:0]           r_ptr;
  logic [1:0]           r_point;
  logic [9:0]           r_x;
  logic [9:0]           r_y;
  logic                 r_clear;

  logic [NUM_SLOTS-1:0] w_shield;
  logic [NUM_SLOTS-1:0] w_accept;
  logic [NUM_SLOTS-1:0] w_alive_next;
  logic [NUM_SLOTS-1:0] w_free_oh;
  logic                 w_free_any;
  logic [2:0]           w_kill;
  logic [5:0]           w_left_next;
  logic [3:0]           w_cnt_dec;
  logic [3:0]           w_blk4;
  logic [2:0]           w_sum;
  logic [1:0]           w_pt;
  logic                 w_pt_ok;

  function automatic logic [9:0] point_x(input logic [1:0] p);
    case (p)
      2'd0:    point_x = 10'd32;
      2'd1:    point_x = 10'd224;
      default: point_x = 10'd416;
    endcase
  endfunction

  assign w_accept     = slot_die_i & r_alive & ~w_shield;
  assign w_alive_next = (r_alive & ~w_accept) | ((r_state == S_SPAWN) ? r_slot_oh : '0);
  assign w_left_next  = (r_left > {3'b000, w_kill}) ? (r_left - {3'b000, w_kill}) : 6'd0;
  assign w_cnt_dec    = (tick_1s_i && r_cnt != 4'd0) ? (r_cnt - 4'd1) : r_cnt;
  // Index 3 never exists; padding it as blocked keeps the search index in range.
  assign w_blk4       = {1'b1, spawn_blocked_i};

  always_comb begin
    w_kill = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_kill = w_kill + {2'b00, w_accept[i]};
    end
  end

  always_comb begin
    w_free_oh  = '0;
    w_free_any = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_alive[i]) begin
        w_free_oh    = '0;
        w_free_oh[i] = 1'b1;
        w_free_any   = 1'b1;
      end
    end
  end

  // Round-robin: scan offsets high to low so the smallest offset from the pointer wins.
  always_comb begin
    w_pt    = '0;
    w_pt_ok = 1'b0;
    w_sum   = '0;
    for (int i = NUM_POINTS - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_ptr} + 3'(i);
      if (w_sum >= 3'(NUM_POINTS)) w_sum = w_sum - 3'(NUM_POINTS);
      if (!w_blk4[w_sum[1:0]]) begin
        w_pt    = w_sum[1:0];
        w_pt_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= S_IDLE;
      r_alive    <= '0;
      r_slot_oh  <= '0;
      r_revive   <= '0;
      r_to_spawn <= '0;
      r_left     <= '0;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_point    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_clear    <= 1'b0;
    end else begin
      r_revive <= '0;
      if (game_start_i) begin
        r_state    <= S_WAIT;
        r_alive    <= '0;
        r_to_spawn <= 6'(ENEMY_TOTAL);
        r_left     <= 6'(ENEMY_TOTAL);
        r_cnt      <= 4'(SPAWN_DELAY_S);
        r_clear    <= 1'b0;
      end else begin
        r_alive <= w_alive_next;
        r_left  <= w_left_next;
        if (r_state != S_IDLE && w_left_next == 6'd0) begin
          r_state <= S_DONE;
          r_clear <= 1'b1;
        end else begin
          case (r_state)
            S_WAIT: begin
              if (game_active_i) begin
                r_cnt <= w_cnt_dec;
                if (w_cnt_dec == 4'd0 && r_to_spawn != 6'd0 && w_free_any) r_state <= S_SELECT;
              end
            end
            S_SELECT: begin
              if (!w_pt_ok) begin
                r_state <= S_WAIT;
                r_cnt   <= 4'd1;
              end else begin
                r_slot_oh <= w_free_oh;
                r_point   <= w_pt;
                r_revive  <= w_free_oh;
                r_x       <= point_x(w_pt);
                r_y       <= SPAWN_Y;
                r_state   <= S_SPAWN;
              end
            end
            S_SPAWN: begin
              r_to_spawn <= r_to_spawn - 6'd1;
              r_ptr      <= (r_point == 2'(NUM_POINTS - 1)) ? 2'd0 : (r_point + 2'd1);
              r_cnt      <= 4'(SPAWN_DELAY_S);
              r_state    <= S_WAIT;
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef ENEMY_SPAWN_SHIELD_EN
  logic [1:0] r_shield_cnt [NUM_SLOTS];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int k = 0; k < NUM_SLOTS; k++) r_shield_cnt[k] <= 2'd0;
    end else if (game_start_i) begin
      for (int k = 0; k < NUM_SLOTS; k++) r_shield_cnt[k] <= 2'd0;
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (r_state == S_SPAWN && r_slot_oh[k]) r_shield_cnt[k] <= 2'd2;
        else if (tick_1s_i && r_shield_cnt[k] != 2'd0) r_shield_cnt[k] <= r_shield_cnt[k] - 2'd1;
      end
    end
  end

  always_comb begin
    w_shield = '0;
    for (int k = 0; k < NUM_SLOTS; k++) w_shield[k] = (r_shield_cnt[k] != 2'd0);
  end
`else
  assign w_shield = '0;
`endif

  assign slot_revive_o = r_revive;
  assign spawn_x_o     = r_x;
  assign spawn_y_o     = r_y;
  assign slot_alive_o  = r_alive;
  assign enemy_left_o  = r_left;
  assign level_clear_o = r_clear;
  assign slot_shield_o = w_shield;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// Directed bench for enemy_spawn_ctrl: default instance plus a 2-enemy instance for the level-clear path.
module tb_enemy_spawn_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       active;
  logic       start, start_s;
  logic [1:0] die, die_s;
  logic [2:0] blocked;

  logic [1:0] revive, alive, shield;
  logic [9:0] sx, sy;
  logic [5:0] left;
  logic       clear;
  logic [2:0] state;

  logic [1:0] revive_s, alive_s, shield_s;
  logic [9:0] sx_s, sy_s;
  logic [5:0] left_s;
  logic       clear_s;
  logic [2:0] state_s;

  int checks   = 0;
  int failures = 0;
  int rev_cnt   = 0;
  int rev_cnt_s = 0;
  int rc;

  always #5 clk = ~clk;

  enemy_spawn_ctrl u_dut (
    .clk_i(clk), .reset_ni(rst_n), .tick_1s_i(tick), .game_start_i(start),
    .game_active_i(active), .slot_die_i(die), .spawn_blocked_i(blocked),
    .slot_revive_o(revive), .spawn_x_o(sx), .spawn_y_o(sy), .slot_alive_o(alive),
    .enemy_left_o(left), .level_clear_o(clear), .slot_shield_o(shield), .dbg_state_o(state)
  );

  enemy_spawn_ctrl #(.NUM_SLOTS(2), .ENEMY_TOTAL(2), .SPAWN_DELAY_S(3)) u_small (
    .clk_i(clk), .reset_ni(rst_n), .tick_1s_i(tick), .game_start_i(start_s),
    .game_active_i(active), .slot_die_i(die_s), .spawn_blocked_i(blocked),
    .slot_revive_o(revive_s), .spawn_x_o(sx_s), .spawn_y_o(sy_s), .slot_alive_o(alive_s),
    .enemy_left_o(left_s), .level_clear_o(clear_s), .slot_shield_o(shield_s), .dbg_state_o(state_s)
  );

  // Each revive pulse is counted once, using the value held just before the edge.
  always @(posedge clk) begin
    if (|revive)   rev_cnt++;
    if (|revive_s) rev_cnt_s++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_die(input logic [1:0] m);
    die = m;
    @(negedge clk);
    die = 2'b00;
  endtask

  task automatic spawn_after(input int n, input logic [1:0] exp_oh, input logic [9:0] exp_x,
                             input string tag);
    int rc0;
    rc0 = rev_cnt;
    for (int i = 0; i < n - 1; i++) pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk({tag, "_early"}, rev_cnt, rc0);
    @(negedge clk);
    chk({tag, "_rev"}, 32'(revive), 32'(exp_oh));
    chk({tag, "_x"}, 32'(sx), 32'(exp_x));
    chk({tag, "_y"}, 32'(sy), 32'd32);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(revive), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; active = 1'b1; start = 1'b0; start_s = 1'b0;
    die = 2'b00; die_s = 2'b00; blocked = 3'b000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_revive", 32'(revive), 32'd0);
    chk("rst_x", 32'(sx), 32'd0);
    chk("rst_y", 32'(sy), 32'd0);
    chk("rst_alive", 32'(alive), 32'd0);
    chk("rst_left", 32'(left), 32'd0);
    chk("rst_clear", 32'(clear), 32'd0);
    chk("rst_shield", 32'(shield), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_left", 32'(left), 32'd20);
    chk("start_state", 32'(state), 32'd1);

    spawn_after(3, 2'b01, 10'd32, "spawn0");
    chk("spawn0_alive", 32'(alive), 32'd1);
    spawn_after(3, 2'b10, 10'd224, "spawn1");
    chk("spawn1_alive", 32'(alive), 32'd3);
    chk("spawn1_left", 32'(left), 32'd20);

    pulse_die(2'b01);
    chk("die0_left", 32'(left), 32'd19);
    chk("die0_alive", 32'(alive), 32'd2);
    spawn_after(3, 2'b01, 10'd416, "wrap");
    chk("wrap_alive", 32'(alive), 32'd3);
    chk("wrap_left", 32'(left), 32'd19);

    pulse_die(2'b10);
    chk("die1_left", 32'(left), 32'd18);
    blocked = 3'b111;
    rc = rev_cnt;
    pulse_tick(); pulse_tick(); pulse_tick();
    @(negedge clk);
    @(negedge clk);
    chk("blocked_norev", rev_cnt, rc);
    chk("blocked_state", 32'(state), 32'd1);
    blocked = 3'b101;
    spawn_after(1, 2'b10, 10'd224, "unblk");
    blocked = 3'b000;

    pulse_die(2'b01);
    chk("die2_left", 32'(left), 32'd17);
    pulse_tick();
    active = 1'b0;
    pulse_die(2'b01);
    chk("dead_die_ignored", 32'(left), 32'd17);
    rc = rev_cnt;
    for (int i = 0; i < 5; i++) pulse_tick();
    @(negedge clk);
    @(negedge clk);
    chk("pause_norev", rev_cnt, rc);
    active = 1'b1;
    spawn_after(2, 2'b01, 10'd416, "pause");

    pulse_tick();
    pulse_tick();
    pulse_die(2'b11);
    chk("dual_left", 32'(left), 32'd15);
    chk("dual_alive", 32'(alive), 32'd0);
    spawn_after(1, 2'b01, 10'd32, "after2");

`ifdef ENEMY_SPAWN_SHIELD_EN
    chk("shield_on", 32'(shield), 32'd1);
    pulse_tick();
    pulse_die(2'b01);
    chk("shield_die_alive", 32'(alive), 32'd1);
    chk("shield_die_left", 32'(left), 32'd15);
    pulse_tick();
    chk("shield_off", 32'(shield), 32'd0);
    pulse_die(2'b01);
    chk("unshield_left", 32'(left), 32'd14);
    chk("unshield_alive", 32'(alive), 32'd0);
`else
    chk("shield_tied", 32'(shield), 32'd0);
`endif

    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk("small_left", 32'(left_s), 32'd2);
    pulse_tick(); pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("small_rev0", 32'(revive_s), 32'd1);
    @(negedge clk);
    pulse_tick(); pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("small_rev1", 32'(revive_s), 32'd2);
    @(negedge clk);
    chk("small_alive", 32'(alive_s), 32'd3);
    die_s = 2'b11;
    @(negedge clk);
    die_s = 2'b00;
    chk("clear_left", 32'(left_s), 32'd0);
    chk("clear_flag", 32'(clear_s), 32'd1);
    chk("clear_state", 32'(state_s), 32'd4);
    rc = rev_cnt_s;
    for (int i = 0; i < 4; i++) pulse_tick();
    chk("clear_norev", rev_cnt_s, rc);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk("restart_left", 32'(left_s), 32'd2);
    chk("restart_clear", 32'(clear_s), 32'd0);
    chk("restart_state", 32'(state_s), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
